// File: rtl/cpu_defs.sv
// Shared CPU encodings: exception FSM states, branch conditions, exception
// causes and their handler vector addresses.
package cpu_defs;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXC_READ = 2'd1,
    ST_EXC_LOAD = 2'd2
  } exc_state_e;

  typedef enum logic [1:0] {
    BR_BEQ = 2'b00,
    BR_BNE = 2'b01,
    BR_BLE = 2'b10,
    BR_BGT = 2'b11
  } branch_op_e;

  typedef enum logic [1:0] {
    EXC_OPCODE = 2'd0,
    EXC_OVF    = 2'd1,
    EXC_DIV0   = 2'd2
  } exc_code_e;

  localparam logic [31:0] VEC_OPCODE = 32'd253;
  localparam logic [31:0] VEC_OVF    = 32'd254;
  localparam logic [31:0] VEC_DIV0   = 32'd255;

  function automatic logic [31:0] vec_addr(input logic [1:0] code);
    case (code)
      EXC_OPCODE: return VEC_OPCODE;
      EXC_OVF:    return VEC_OVF;
      EXC_DIV0:   return VEC_DIV0;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/pc_exception_unit_if.sv
// Handler-vector read port between the exception unit and memory.
interface pc_exception_unit_if;
  logic        exc_mem_rd;
  logic [31:0] exc_mem_addr;
  logic [7:0]  mem_rdata;

  modport master (output exc_mem_rd, output exc_mem_addr, input mem_rdata);
  modport slave  (input exc_mem_rd, input exc_mem_addr, output mem_rdata);
endinterface

// File: rtl/branch_cond_eval.sv
// Evaluates the branch condition from the ALU flags.
module branch_cond_eval
  import cpu_defs::*;
(
  input  logic [1:0] branch_op,
  input  logic       zero,
  input  logic       gt,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (branch_op_e'(branch_op))
      BR_BEQ:  cond_true = zero;
      BR_BNE:  cond_true = !zero;
      BR_BLE:  cond_true = !gt;
      BR_BGT:  cond_true = gt;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_exception_unit.sv
// Program counter with exception sequencing: saves EPC, reads the handler
// byte from the cause's vector address and jumps to it.
module pc_exception_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_LAT  = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                pc_next,
  input  logic                       pc_write,
  input  logic                       pc_write_cond,
  input  logic [1:0]                 branch_op,
  input  logic                       zero,
  input  logic                       gt,
  input  logic                       exc_opcode,
  input  logic                       exc_ovf,
  input  logic                       exc_div0,
  pc_exception_unit_if.master        mem,
  output logic [31:0]                pc,
  output logic [31:0]                epc,
  output logic                       exc_busy,
  output logic [1:0]                 exc_code
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  exc_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  code_q, code_d;
  logic        cond_true;
  logic        exc_req;
  logic        rd;
  logic [31:0] addr;

  branch_cond_eval u_cond (
    .branch_op (branch_op),
    .zero      (zero),
    .gt        (gt),
    .cond_true (cond_true)
  );

  assign exc_req = exc_opcode | exc_div0 | exc_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    code_d  = code_q;
    rd      = 1'b0;
    addr    = '0;
    case (state_q)
      ST_IDLE: begin
        if (exc_req) begin
          epc_d   = pc_q - 32'd4;
          code_d  = exc_opcode ? EXC_OPCODE : (exc_div0 ? EXC_DIV0 : EXC_OVF);
          cnt_d   = LAT;
          state_d = ST_EXC_READ;
        end else if (pc_write | (pc_write_cond & cond_true)) begin
          pc_d = pc_next;
        end
      end
      ST_EXC_READ: begin
        cnt_d = cnt_q - 3'd1;
        // Counter is only at its load value during the first read cycle.
        if (cnt_q == LAT) begin
          rd   = 1'b1;
          addr = vec_addr(code_q);
        end
        if (cnt_q == 3'd1) state_d = ST_EXC_LOAD;
      end
      ST_EXC_LOAD: begin
        pc_d    = {24'b0, mem.mem_rdata};
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem.exc_mem_rd   = rd;
  assign mem.exc_mem_addr = addr;
  assign pc               = pc_q;
  assign epc              = epc_q;
  assign exc_code         = code_q;
  assign exc_busy         = (state_q != ST_IDLE);

endmodule

// File: doc/pc_exception_unit.md
PC_EXCEPTION_UNIT -- requirements
Module: pc_exception_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter MEM_LAT, default 2, the memory read latency in cycles (legal range 1..7).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port pc_next, input, 32, the next-PC value from the PC source selector.
REQ-006 SHALL have port pc_write, input, 1, the unconditional PC write request.
REQ-007 SHALL have port pc_write_cond, input, 1, the conditional (branch) PC write request.
REQ-008 SHALL have port branch_op, input, 2, the branch condition: 00 BEQ, 01 BNE, 10 BLE, 11 BGT.
REQ-009 SHALL have ports zero and gt, input, 1 each, the ALU flags.
REQ-010 SHALL have ports exc_opcode, exc_ovf and exc_div0, input, 1 each, the exception requests.
REQ-011 SHALL have port mem_rdata, input, 8, the byte returned by memory for a vector read.
REQ-012 SHALL have port pc, output, 32, the program counter register.
REQ-013 SHALL have port epc, output, 32, the exception PC register (it feeds PC source 4).
REQ-014 SHALL have ports exc_mem_rd (output, 1) and exc_mem_addr (output, 32), the vector read request.
REQ-015 SHALL have port exc_busy, output, 1, high while an exception sequence runs; the control unit stalls on it.
REQ-016 SHALL have port exc_code, output, 2, the latched cause: 0 opcode, 1 overflow, 2 div0.

Function
REQ-017 SHALL define cond_true as: BEQ=zero, BNE=!zero, BLE=!gt, BGT=gt.
REQ-018 SHALL write pc<=pc_next in IDLE when pc_write | (pc_write_cond & cond_true), and no exception is requested; otherwise pc holds.
REQ-019 SHALL implement FSM states IDLE, EXC_READ and EXC_LOAD.
REQ-020 SHALL, in IDLE with any exception input high, at the next edge: set epc<=pc-4 (modulo 2^32), latch exc_code, load the counter with MEM_LAT, and enter EXC_READ.
REQ-021 SHALL resolve simultaneous exception requests by priority: exc_opcode > exc_div0 > exc_ovf.
REQ-022 SHALL give an exception priority over a PC write in the same cycle; pc is not written in that case.
REQ-023 SHALL, in EXC_READ, drive exc_mem_rd=1 only in its first cycle and drive exc_mem_addr = 253/254/255 for code 0/1/2.
REQ-024 SHALL, in EXC_READ, decrement the counter every cycle and go to EXC_LOAD when the counter reaches 1.
REQ-025 SHALL, in EXC_LOAD, set pc<={24'b0, mem_rdata} and return to IDLE.
REQ-026 SHALL hold exc_busy=1 in EXC_READ and EXC_LOAD, and 0 in IDLE.
REQ-027 SHALL ignore pc_write, pc_write_cond and all exception inputs while exc_busy=1.
REQ-028 SHALL give a latency of MEM_LAT+2 edges from exception sample to handler PC; epc is stable from edge 1.
REQ-029 SHALL drive exc_mem_addr=0 whenever exc_mem_rd=0.

Reset
REQ-030 SHALL, on reset_n low, immediately set pc=RESET_PC, epc=0, state=IDLE, counter=0, exc_code=0, exc_busy=0 and exc_mem_rd=0.
REQ-031 SHALL, on reset during EXC_READ or EXC_LOAD, abort the sequence and never write pc from mem_rdata afterwards.

Structure
REQ-032 SHALL take the FSM state encoding, the branch_op codes, the exception codes and the vector addresses 253/254/255 from the shared package cpu_defs.
REQ-033 SHALL put the condition evaluation (REQ-017) in the sub-module branch_cond_eval; all sequential logic stays in pc_exception_unit.

Verification
REQ-034 SHALL cover: reset with RESET_PC=0 -> pc=0, epc=0, exc_busy=0.
REQ-035 SHALL cover: pc_write_cond=1, branch_op=01, zero=0, pc_next=0x40 -> pc=0x40 next edge; with zero=1 -> pc holds.
REQ-036 SHALL cover: pc=0x1C, exc_ovf=1, MEM_LAT=2, mem_rdata=0x80 -> epc=0x18, exc_mem_addr=254 with one-cycle rd, pc=0x80 after 4 edges, exc_busy high for 3 cycles.
REQ-037 SHALL cover: exc_opcode, exc_div0 and pc_write all high -> exc_code=0, addr 253, pc not loaded from pc_next.
REQ-038 SHALL cover: exc_div0 pulsed again during exc_busy -> ignored, a single sequence only.
REQ-039 SHALL cover: reset_n low in EXC_READ -> IDLE, pc=RESET_PC, and no later handler load.
